// File: rtl/ifft_symbol_scheduler_if.sv
// Handshake bundle between the slot controller, the sample buffer and the IFFT
// first-stage butterfly. master = driving controller side, slave = scheduler.
interface ifft_symbol_scheduler_if;
    logic        start;
    logic        long_cp_slot;
    logic        src_ready;
    logic        abort;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic        valid_out;
    logic [3:0]  sym_idx;
    logic [9:0]  cp_len;
    logic        sym_start;
    logic        slot_done;
    logic        busy;

    modport master (
        output start, long_cp_slot, src_ready, abort,
        input  rd_en, rd_addr, valid_out, sym_idx, cp_len, sym_start, slot_done, busy
    );

    modport slave (
        input  start, long_cp_slot, src_ready, abort,
        output rd_en, rd_addr, valid_out, sym_idx, cp_len, sym_start, slot_done, busy
    );
endinterface

// File: rtl/ifft_symbol_scheduler.sv
// Streams one OFDM slot of symbols from the sample buffer into the IFFT first stage.
// Define EXT_CP_EN for extended-CP slots (12 symbols, cp_len fixed at 512).
//
//   state    | meaning
//   IDLE     | waiting for start
//   WAIT_SRC | waiting for the buffer to hold a complete symbol
//   STREAM   | reading N consecutive samples
//   GAP      | holding input idle while the butterfly drains
//   DONE     | one-cycle slot_done pulse
module ifft_symbol_scheduler #(
    parameter int N             = 2048,
    parameter int GAP_CYCLES    = 1025,
    parameter int SYMS_PER_SLOT = 14,
    parameter int CP_SHORT      = 144,
    parameter int CP_LONG       = 160,
    parameter int LONG_AT_7     = 1
) (
    input logic clk,
    input logic rst,
    ifft_symbol_scheduler_if.slave bus
);

`ifdef EXT_CP_EN
    localparam int SYMS = 12;
`else
    localparam int SYMS = SYMS_PER_SLOT;
`endif
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WAIT_SRC, STREAM, GAP, DONE} state_t;

    state_t      state, state_nxt;
    logic [GW-1:0] gap_cnt, gap_cnt_nxt;
    logic [11:0] rd_addr_q, addr_nxt;
    logic [3:0]  sym_q, sym_nxt;
    logic [9:0]  cp_q, cp_nxt, cp_sel;
    logic        long_q, long_nxt;
    logic        sym_start_nxt;
    logic        rd_en_q, valid_q, sym_start_q, slot_done_q, busy_q;

    always_comb begin
`ifdef EXT_CP_EN
        cp_sel = 10'd512;
`else
        cp_sel = 10'(CP_SHORT);
        if (long_q && (sym_q == 4'd0 || (LONG_AT_7 != 0 && sym_q == 4'd7)))
            cp_sel = 10'(CP_LONG);
`endif
    end

    always_comb begin
        state_nxt     = state;
        gap_cnt_nxt   = gap_cnt;
        addr_nxt      = 12'd0;
        sym_nxt       = sym_q;
        long_nxt      = long_q;
        cp_nxt        = cp_q;
        sym_start_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = WAIT_SRC;
                    long_nxt  = bus.long_cp_slot;
                    sym_nxt   = 4'd0;
                end
            end
            WAIT_SRC: begin
                if (bus.src_ready) begin
                    state_nxt     = STREAM;
                    sym_start_nxt = 1'b1;
                    cp_nxt        = cp_sel;
                end
            end
            STREAM: begin
                if (rd_addr_q == 12'(N - 1)) begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = GW'(GAP_CYCLES - 1);
                end else begin
                    addr_nxt = rd_addr_q + 12'd1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    if (sym_q == 4'(SYMS - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        sym_nxt   = sym_q + 4'd1;
                        state_nxt = WAIT_SRC;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort drops the slot silently; a partially fed butterfly is recovered by reset.
        if (state != IDLE && bus.abort) begin
            state_nxt     = IDLE;
            gap_cnt_nxt   = '0;
            addr_nxt      = 12'd0;
            sym_nxt       = 4'd0;
            cp_nxt        = cp_q;
            sym_start_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            rd_addr_q   <= 12'd0;
            sym_q       <= 4'd0;
            long_q      <= 1'b0;
            cp_q        <= 10'd0;
            rd_en_q     <= 1'b0;
            valid_q     <= 1'b0;
            sym_start_q <= 1'b0;
            slot_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            gap_cnt     <= gap_cnt_nxt;
            rd_addr_q   <= addr_nxt;
            sym_q       <= sym_nxt;
            long_q      <= long_nxt;
            cp_q        <= cp_nxt;
            rd_en_q     <= (state_nxt == STREAM);
            valid_q     <= rd_en_q;
            sym_start_q <= sym_start_nxt;
            slot_done_q <= (state_nxt == DONE);
            busy_q      <= (state_nxt != IDLE);
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.valid_out = valid_q;
    assign bus.sym_idx   = sym_q;
    assign bus.cp_len    = cp_q;
    assign bus.sym_start = sym_start_q;
    assign bus.slot_done = slot_done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ifft_symbol_scheduler.sv
// Bench for ifft_symbol_scheduler: a full-size instance checked every cycle against a
// timeline model, plus a reduced-size instance with LONG_AT_7=0 for the CP-rule variant.
`timescale 1ns/1ps
module tb_ifft_symbol_scheduler;
    localparam int N    = 2048;
    localparam int GAP  = 1025;
    localparam int SN   = 16;
    localparam int SGAP = 9;
`ifdef EXT_CP_EN
    localparam int SYMS = 12;
    localparam bit EXT  = 1'b1;
`else
    localparam int SYMS = 14;
    localparam bit EXT  = 1'b0;
`endif
    localparam int CP_L = EXT ? 512 : 160;
    localparam int CP_S = EXT ? 512 : 144;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifft_symbol_scheduler_if bus();
    ifft_symbol_scheduler_if bus7();

    ifft_symbol_scheduler u_dut (.clk(clk), .rst(rst), .bus(bus));
    ifft_symbol_scheduler #(.N(SN), .GAP_CYCLES(SGAP), .LONG_AT_7(0))
        u_dut7 (.clk(clk), .rst(rst), .bus(bus7));

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: position within the symbol timeline (-1 = waiting for source).
    bit m_act = 0, m_done = 0, m_long = 0, m_valid = 0;
    int m_pos = -1, m_sym = 0, m_cp = 0;

    int ss_cyc[$];
    int ss_cp[$];
    int last_rd = 0, done_cyc = 0, done_cnt = 0;
    int n7 = 0, d7 = 0, s7_last = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int cp_rule(input int s, input bit lng);
        if (EXT) return 512;
        return (lng && (s == 0 || s == 7)) ? 160 : 144;
    endfunction

    function automatic int cp7_exp(input int s);
        if (EXT) return 512;
        return (s == 0) ? 160 : 144;
    endfunction

    function automatic logic [30:0] model_vec();
        logic re;
        int   a;
        re = m_act && !m_done && m_pos >= 0 && m_pos < N;
        a  = re ? m_pos : 0;
        return {re, 12'(a), m_valid, 4'(m_sym), 10'(m_cp), re && (m_pos == 0), m_done, m_act};
    endfunction

    function automatic logic [30:0] dut_vec();
        return {bus.rd_en, bus.rd_addr, bus.valid_out, bus.sym_idx, bus.cp_len,
                bus.sym_start, bus.slot_done, bus.busy};
    endfunction

    always @(posedge clk) begin
        logic [30:0] pv;
        pv  = model_vec();
        cyc = cyc + 1;
        if (rst) begin
            m_act = 0; m_done = 0; m_long = 0; m_valid = 0;
            m_pos = -1; m_sym = 0; m_cp = 0;
        end else begin
            m_valid = pv[30];
            if (m_act && bus.abort) begin
                m_act = 0; m_done = 0; m_pos = -1; m_sym = 0;
            end else if (!m_act) begin
                if (bus.start && !bus.abort) begin
                    m_act = 1; m_long = bus.long_cp_slot; m_sym = 0; m_pos = -1;
                end
            end else if (m_done) begin
                m_done = 0; m_act = 0;
            end else if (m_pos < 0) begin
                if (bus.src_ready) begin
                    m_pos = 0;
                    m_cp  = cp_rule(m_sym, m_long);
                end
            end else if (m_pos == N + GAP - 1) begin
                m_pos = -1;
                if (m_sym == SYMS - 1) m_done = 1;
                else m_sym = m_sym + 1;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("outputs", 64'(dut_vec()), 64'(model_vec()));
            if (bus.sym_start) begin
                ss_cyc.push_back(cyc);
                ss_cp.push_back(int'(bus.cp_len));
            end
            if (bus.rd_en && bus.rd_addr == 12'(N - 1)) last_rd = cyc;
            if (bus.slot_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus7.sym_start) begin
                chk("small_sym_idx", 64'(bus7.sym_idx), 64'(n7));
                chk("small_cp_len", 64'(bus7.cp_len), 64'(cp7_exp(n7)));
                if (n7 > 0) chk("small_period", 64'(cyc - s7_last), 64'(1 + SN + SGAP));
                s7_last = cyc;
                n7++;
            end
            if (bus7.slot_done) d7++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_src_burst_random();
        if (m_act && m_pos >= 0 && m_pos < N) bus.src_ready = 1'($urandom_range(0, 1));
        else bus.src_ready = 1'b1;
    endtask

    initial begin
        int c;
        int bp_cnt;
        bus.start = 0; bus.long_cp_slot = 0; bus.src_ready = 1; bus.abort = 0;
        bus7.start = 0; bus7.long_cp_slot = 1; bus7.src_ready = 1; bus7.abort = 0;
        rst = 1;
        repeat (3) tick();
        rst = 0;
        chk("reset_outputs", 64'(dut_vec()), 64'd0);

        // Slot 1: long CP, backpressure before symbol 4, stray start during GAP of symbol 5.
        ss_cyc.delete(); ss_cp.delete(); done_cnt = 0;
        bus.long_cp_slot = 1; bus.start = 1; bus7.start = 1;
        tick();
        bus.start = 0; bus7.start = 0;
        c = 0; bp_cnt = 0;
        while (m_act && c < 50000) begin
            drive_src_burst_random();
            if (m_sym == 4 && m_pos < 0 && bp_cnt < 500) begin
                bus.src_ready = 1'b0;
                bp_cnt++;
            end
            bus.start = (m_sym == 5 && m_pos == N + 100) || ($urandom_range(0, 511) == 0);
            bus.long_cp_slot = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        bus.start = 0; bus.src_ready = 1;
        if (c >= 50000) begin
            checks++; errors++;
            $display("FAIL slot1_timeout: got %0d cycles required fewer than 50000", c);
        end
        tick();
        chk("slot1_sym_count", 64'(ss_cyc.size()), 64'(SYMS));
        chk("slot1_period_0_1", 64'(ss_cyc[1] - ss_cyc[0]), 64'd3074);
        chk("slot1_backpressure_3_4", 64'(ss_cyc[4] - ss_cyc[3]), 64'd3574);
        chk("slot1_period_5_6", 64'(ss_cyc[6] - ss_cyc[5]), 64'd3074);
        chk("slot1_cp_sym0", 64'(ss_cp[0]), 64'(CP_L));
        chk("slot1_cp_sym3", 64'(ss_cp[3]), 64'(CP_S));
        chk("slot1_cp_sym7", 64'(ss_cp[7]), 64'(CP_L));
        chk("slot1_done_count", 64'(done_cnt), 64'd1);
        chk("slot1_done_gap", 64'(done_cyc - last_rd - 1), 64'd1025);

        // Slot 2: short CP, abort at rd_addr 1000 of symbol 2.
        ss_cyc.delete(); ss_cp.delete(); done_cnt = 0;
        bus.long_cp_slot = 0; bus.start = 1;
        tick();
        bus.start = 0;
        c = 0;
        while (!(m_sym == 2 && m_pos == 1000) && c < 12000) begin
            drive_src_burst_random();
            tick();
            c++;
        end
        if (c >= 12000) begin
            checks++; errors++;
            $display("FAIL abort_setup_timeout: got %0d cycles required fewer than 12000", c);
        end
        chk("abort_at_addr", 64'(bus.rd_addr), 64'd1000);
        bus.abort = 1;
        tick();
        bus.abort = 0;
        chk("abort_rd_en", 64'(bus.rd_en), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_sym_idx", 64'(bus.sym_idx), 64'd0);
        chk("abort_valid_lag", 64'(bus.valid_out), 64'd1);
        tick();
        chk("abort_valid_fall", 64'(bus.valid_out), 64'd0);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("slot2_cp_sym1", 64'(ss_cp[1]), 64'(CP_S));

        // abort and start together in IDLE: abort wins.
        bus.start = 1; bus.abort = 1;
        tick();
        bus.start = 0; bus.abort = 0;
        chk("abort_start_idle_busy", 64'(bus.busy), 64'd0);
        tick();

        // Restart after abort, then reset mid-burst.
        bus.long_cp_slot = 1; bus.start = 1; bus.src_ready = 1;
        tick();
        bus.start = 0;
        c = 0;
        while (m_pos != 0 && c < 10) begin tick(); c++; end
        chk("restart_sym_start", 64'(bus.sym_start), 64'd1);
        chk("restart_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("restart_sym_idx", 64'(bus.sym_idx), 64'd0);
        chk("restart_cp_len", 64'(bus.cp_len), 64'(CP_L));
        c = 0;
        while (m_pos != 500 && c < 600) begin drive_src_burst_random(); tick(); c++; end
        rst = 1;
        tick();
        rst = 0;
        chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_cp_len", 64'(bus.cp_len), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);

        // Slot 3: random source readiness everywhere, abort while waiting for symbol 2.
        bus.long_cp_slot = 0; bus.start = 1;
        tick();
        bus.start = 0;
        c = 0;
        while (!(m_sym == 2 && m_pos < 0) && c < 8000) begin
            bus.src_ready = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        if (c >= 8000) begin
            checks++; errors++;
            $display("FAIL slot3_timeout: got %0d cycles required fewer than 8000", c);
        end
        bus.abort = 1;
        tick();
        bus.abort = 0;
        chk("slot3_abort_busy", 64'(bus.busy), 64'd0);
        repeat (4) tick();

        chk("small_sym_count", 64'(n7), 64'(SYMS));
        chk("small_done_count", 64'(d7), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ifft_symbol_scheduler.md
Name: ifft_symbol_scheduler

Overview:
- Sequences OFDM symbols from the frequency-domain sample buffer into the first-stage radix-2 butterfly of the 2048-point IFFT.
- Per symbol: streams N samples as one contiguous burst, then holds input invalid while the butterfly drains its subtraction half.
- Tags each symbol with its index and cyclic-prefix length, for use by the downstream CP inserter.
- Sits between the sample buffer and the butterfly, and runs one slot per start request.

Parameters:
- N, 2048: IFFT size; samples per symbol burst.
- GAP_CYCLES, 1025: idle cycles after a burst (butterfly drain of N/2 plus its 1-cycle IDLE return).
- SYMS_PER_SLOT, 14: symbols per slot (normal CP).
- CP_SHORT, 144: normal CP length in samples.
- CP_LONG, 160: long CP length in samples.
- LONG_AT_7, 1: when 1, symbol 7 also gets CP_LONG in long-CP slots (numerology 0).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begin a slot (sampled in IDLE only)
- long_cp_slot  in  1  slot contains a half-subframe boundary; sampled with start
- src_ready  in  1  buffer holds a complete symbol
- abort  in  1  synchronous abort of the current slot
- rd_en  out  1  buffer read strobe
- rd_addr  out  12  sample address within the symbol
- valid_out  out  1  drives the butterfly VALID_R and VALID_I
- sym_idx  out  4  index of the symbol being streamed
- cp_len  out  10  CP length for sym_idx
- sym_start  out  1  pulse on the first rd_en of each symbol
- slot_done  out  1  pulse after the last symbol's gap completes
- busy  out  1  high in every state except IDLE

Behaviour:
- One clock (clk). rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; counters 0.
- All outputs are registered.
- States and transitions:
  - IDLE: on start, latch long_cp_slot, sym_idx<=0, go to WAIT_SRC. busy=1 from the next cycle.
  - WAIT_SRC: when src_ready=1, go to STREAM. Stays in WAIT_SRC indefinitely while src_ready=0.
  - STREAM: rd_en=1 for exactly N consecutive cycles, with rd_addr 0..N-1 incrementing by 1.
    - sym_start=1 together with rd_addr=0.
    - After rd_addr=N-1, go to GAP. rd_addr returns to 0.
  - GAP: rd_en=0 for exactly GAP_CYCLES cycles. Then:
    - if sym_idx==SYMS_PER_SLOT-1: go to DONE;
    - else: sym_idx+1 and go to WAIT_SRC.
  - DONE: slot_done=1 for one cycle; go to IDLE.
- valid_out is rd_en delayed by one cycle (1-cycle buffer read latency), so the butterfly sees exactly N valid samples per symbol.
- src_ready is sampled only in WAIT_SRC. Deassertion during STREAM is ignored; the burst is never split.
- cp_len is updated when sym_start is asserted and held until the next sym_start:
  - CP_LONG if latched long_cp_slot=1 and (sym_idx==0, or LONG_AT_7=1 and sym_idx==7);
  - else CP_SHORT.
  - Width: zero-extended to 10 bits.
- start while busy: ignored; no queuing.
- abort, any non-IDLE state:
  - next cycle: state IDLE, rd_en=0, rd_addr=0, sym_idx=0, busy=0; slot_done is not pulsed.
  - valid_out falls one cycle later.
  - Abort forces the butterfly to see a short burst; the system restarts the butterfly by reset.
- abort and start in the same cycle in IDLE: abort wins and start is ignored.
- rst mid-operation: same as abort, and additionally clears valid_out and cp_len in the same cycle.
- Minimum symbol period with src_ready held high: 1 (WAIT_SRC) + N + GAP_CYCLES cycles = 3074 for the defaults.

Optional Feature:
- Macro: EXT_CP_EN.
- Defined:
  - extended CP mode: SYMS_PER_SLOT is forced to 12;
  - cp_len = 512 for every symbol;
  - long_cp_slot is ignored.
- Undefined: normal-CP behaviour as above. The 10-bit cp_len width is kept in both builds.

Test Plan:
- Basic slot, defaults, long_cp_slot=0, src_ready=1 throughout:
  - 14 sym_start pulses spaced 3074 cycles apart;
  - each burst has 2048 rd_en with rd_addr 0..2047 and valid_out lagging 1 cycle;
  - cp_len=144 for all 14 symbols; slot_done 1025 cycles after the last rd_addr=2047.
- long_cp_slot=1 at start:
  - cp_len=160 for sym_idx 0 and 7, 144 for the rest;
  - with LONG_AT_7=0, only sym_idx 0 gets 160.
- Backpressure: src_ready=0 for 500 cycles after the GAP of symbol 3 ends -> rd_en stays 0 and sym_idx stays 4 until src_ready rises; the burst then starts next cycle and is uninterrupted even if src_ready drops mid-burst.
- abort at rd_addr=1000 of symbol 2:
  - next cycle: rd_en=0, busy=0, sym_idx=0; no slot_done;
  - a new start then begins again at sym_idx=0 with rd_addr=0.
- start pulsed during GAP of symbol 5 -> ignored; the slot still ends after 14 symbols with a single slot_done.
- EXT_CP_EN build -> exactly 12 symbols, cp_len=512 each, slot_done after symbol 11.
